// File: rtl/lfsr_chk_if.sv
// lfsr_chk_if: serial stream in, lock/error status out; bit_cnt exists only under LFSR_CHK_BITCNT_EN.
interface lfsr_chk_if #(parameter int CNT_W = 16);
  logic din, din_vaild, err_clr, locked, err_pulse;
  logic [CNT_W-1:0] err_cnt;
`ifdef LFSR_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt;
  modport master(output din, din_vaild, err_clr, input locked, err_pulse, err_cnt, bit_cnt);
  modport slave(input din, din_vaild, err_clr, output locked, err_pulse, err_cnt, bit_cnt);
`else
  modport master(output din, din_vaild, err_clr, input locked, err_pulse, err_cnt);
  modport slave(input din, din_vaild, err_clr, output locked, err_pulse, err_cnt);
`endif
endinterface

// File: rtl/lfsr_chk.sv
// lfsr_chk: self-synchronising LFSR stream checker with saturating error count.
// Optional locked-bit counter on bus.bit_cnt when LFSR_CHK_BITCNT_EN is defined.
module lfsr_chk #(
  parameter int wid      = 4,
  parameter int LOCK_CNT = 8,
  parameter int MISS_MAX = 4,
  parameter int CNT_W    = 16
) (
  input logic        clk,
  input logic        rest,
  lfsr_chk_if.slave  bus
);
  localparam int LW = $clog2(wid + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(MISS_MAX + 1);
  typedef enum logic [1:0] {LOAD, HUNT, LOCKED} state_t;
  state_t state_q, state_d;
  logic [wid-1:0] r_q, r_d;
  logic [LW-1:0] ld_q, ld_d;
  logic [MW-1:0] mt_q, mt_d;
  logic [SW-1:0] ms_q, ms_d;
  logic err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic p, mis;
  assign p   = ^r_q[wid-2:0];
  assign mis = bus.din ^ p;
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    ld_d        = ld_q;
    mt_d        = mt_q;
    ms_d        = ms_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (bus.din_vaild)
      case (state_q)
        LOAD: begin
          r_d  = {bus.din, r_q[wid-1:1]};
          ld_d = ld_q + LW'(1);
          if (ld_q == LW'(wid - 1)) begin
            state_d = HUNT;
            ld_d    = '0;
          end
        end
        HUNT: begin
          r_d  = {bus.din, r_q[wid-1:1]};
          mt_d = mis ? '0 : mt_q + MW'(1);
          if (!mis && mt_q == MW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            mt_d    = '0;
          end
        end
        LOCKED: begin
          // Free-running: the prediction, not din, feeds back so one flip is one error.
          r_d  = {p, r_q[wid-1:1]};
          ms_d = mis ? ms_q + SW'(1) : '0;
          if (mis) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
          end
          if (mis && ms_q == SW'(MISS_MAX - 1)) begin
            state_d = LOAD;
            r_d     = '0;
            ms_d    = '0;
          end
        end
        default: state_d = LOAD;
      endcase
    if (bus.err_clr) err_cnt_d = '0;
  end
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q     <= LOAD;
      r_q         <= '0;
      ld_q        <= '0;
      mt_q        <= '0;
      ms_q        <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      ld_q        <= ld_d;
      mt_q        <= mt_d;
      ms_q        <= ms_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
  assign bus.locked    = state_q == LOCKED;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;
`ifdef LFSR_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (bus.din_vaild && state_q == LOCKED && !(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    if (bus.err_clr) bit_cnt_d = '0;
  end
  always_ff @(posedge clk) begin
    if (!rest) bit_cnt_q <= '0;
    else bit_cnt_q <= bit_cnt_d;
  end
  assign bus.bit_cnt = bit_cnt_q;
`endif
endmodule

// File: tb/tb_lfsr_chk.sv
// tb_lfsr_chk: directed stream scenarios; per-cycle expectations queued by the driver, checked by a monitor.
module tb_lfsr_chk;
  logic clk = 1'b0;
  logic rest = 1'b0;
  lfsr_chk_if #(.CNT_W(3)) bus();
  lfsr_chk #(.wid(4), .LOCK_CNT(8), .MISS_MAX(4), .CNT_W(3)) dut (
    .clk(clk),
    .rest(rest),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    int id;
    logic l;
    logic p;
    logic [2:0] c;
  } exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0, id = 0, idx = 0, vn = 0;
  logic [6:0] pat = 7'b0111001;
  task automatic drive(input logic r, input logic v, input logic d, input logic c,
                       input logic el, input logic ep, input logic [2:0] ec);
    rest = r;
    bus.din_vaild = v;
    bus.din = d;
    bus.err_clr = c;
    @(posedge clk);
    exp_q.push_back('{id, el, ep, ec});
    id++;
    #1;
  endtask
  task automatic sb(input logic flip, input logic c, input logic el, input logic ep, input logic [2:0] ec);
    drive(1'b1, 1'b1, pat[idx % 7] ^ flip, c, el, ep, ec);
    idx++;
  endtask
  task automatic rst1();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    idx = 0;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({bus.locked, bus.err_pulse, bus.err_cnt} !== {e.l, e.p, e.c}) begin
        bad++;
        $display("FAIL step%0d: got locked=%0b pulse=%0b cnt=%0d, want locked=%0b pulse=%0b cnt=%0d",
                 e.id, bus.locked, bus.err_pulse, bus.err_cnt, e.l, e.p, e.c);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.din = 1'b0;
    bus.din_vaild = 1'b0;
    bus.err_clr = 1'b0;
    @(posedge clk);
    #1;
    rst1();
    rst1();
    // clean lock-up: locked after the 12th bit, no errors
    for (int k = 1; k <= 100; k++) sb(1'b0, 1'b0, k >= 12, 1'b0, 3'd0);
    // single flipped bit while locked
    rst1();
    for (int k = 1; k <= 40; k++) sb(k == 20, 1'b0, k >= 12, k == 20, 3'(k >= 20 ? 1 : 0));
    // four consecutive inverted bits drop lock, relock 12 bits later
    rst1();
    for (int k = 1; k <= 50; k++)
      sb(k >= 21 && k <= 24, 1'b0, (k >= 12 && k <= 23) || k >= 36, k >= 21 && k <= 24,
         3'(k < 21 ? 0 : (k >= 24 ? 4 : k - 20)));
    // gapped valid with garbage on invalid cycles
    rst1();
    vn = 0;
    for (int k = 0; k < 60; k++)
      if (k % 2 == 0) begin
        vn++;
        sb(1'b0, 1'b0, vn >= 12, 1'b0, 3'd0);
      end else drive(1'b1, 1'b0, ~pat[idx % 7], 1'b0, vn >= 12, 1'b0, 3'd0);
    // saturation at 7, then clear beats a same-cycle error
    rst1();
    for (int k = 1; k <= 12; k++) sb(1'b0, 1'b0, k >= 12, 1'b0, 3'd0);
    for (int e = 1; e <= 9; e++) begin
      sb(1'b1, 1'b0, 1'b1, 1'b1, 3'(e > 7 ? 7 : e));
      repeat (3) sb(1'b0, 1'b0, 1'b1, 1'b0, 3'(e > 7 ? 7 : e));
    end
    sb(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    sb(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    sb(1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    sb(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    sb(1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    // reset mid-lock clears everything; relock needs a full 12 bits
    rst1();
    for (int k = 1; k <= 14; k++) sb(1'b0, 1'b0, k >= 12, 1'b0, 3'd0);
    bus.din_vaild = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
